// File: rtl/multiport_clock_cache_if.sv
// multiport_clock_cache_if: read channels, write/invalidate channel and eviction report
interface multiport_clock_cache_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32,
  parameter int NUM_RD = 2
);
  logic [NUM_RD-1:0] rd_valid;
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD-1:0] rd_done;
  logic [NUM_RD-1:0] rd_hit;
  logic [NUM_RD*LINE_WIDTH-1:0] rd_val;
  logic wr_req;
  logic wr_inval;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [LINE_WIDTH-1:0] wr_val;
  logic wr_ready;
  logic wr_done;
  logic wr_hit;
  logic evict_valid;
  logic [ADDR_WIDTH-1:0] evict_addr;
  modport master (
    output rd_valid, rd_addr, wr_req, wr_inval, wr_addr, wr_val,
    input rd_done, rd_hit, rd_val, wr_ready, wr_done, wr_hit, evict_valid, evict_addr
  );
  modport slave (
    input rd_valid, rd_addr, wr_req, wr_inval, wr_addr, wr_val,
    output rd_done, rd_hit, rd_val, wr_ready, wr_done, wr_hit, evict_valid, evict_addr
  );
endinterface

// File: rtl/multiport_clock_cache.sv
// multiport_clock_cache: fully-associative K-line cache, NUM_RD read ports, CLOCK second-chance eviction
module multiport_clock_cache #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32,
  parameter int K = 4,
  parameter int NUM_RD = 2
) (
  input logic clock,
  input logic reset,
  multiport_clock_cache_if.slave bus
);
  localparam int PW = $clog2(K);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
  logic [0:0] state;
  logic [PW-1:0] ptr, w_idx, f_idx;
  logic [K-1:0] valid, refb, rd_ref;
  logic [K-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [K-1:0][LINE_WIDTH-1:0] val_q;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [LINE_WIDTH-1:0] lat_val;
  logic w_hit, any_free, accept;
  logic [NUM_RD-1:0] hit_c;
  logic [NUM_RD*LINE_WIDTH-1:0] val_c;
  assign bus.wr_ready = !reset && state == IDLE;
  assign accept = bus.wr_req && bus.wr_ready;
  // addresses are unique across valid lines, so OR-reducing matches yields the single hit
  always_comb begin
    rd_ref = '0;
    hit_c = '0;
    val_c = '0;
    w_hit = 1'b0;
    w_idx = '0;
    any_free = 1'b0;
    f_idx = '0;
    for (int k = K - 1; k >= 0; k--)
      if (!valid[k]) begin
        any_free = 1'b1;
        f_idx = PW'(k);
      end
    for (int k = 0; k < K; k++) begin
      if (valid[k] && addr_q[k] == bus.wr_addr) begin
        w_hit = 1'b1;
        w_idx = PW'(k);
      end
      for (int i = 0; i < NUM_RD; i++)
        if (bus.rd_valid[i] && valid[k] && addr_q[k] == bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
          rd_ref[k] = 1'b1;
          hit_c[i] = 1'b1;
          val_c[i*LINE_WIDTH +: LINE_WIDTH] = val_c[i*LINE_WIDTH +: LINE_WIDTH] | val_q[k];
        end
    end
  end
  // later per-line assignments override the read-hit ref refresh where a write owns the line
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      refb <= '0;
      ptr <= '0;
      state <= IDLE;
      bus.rd_done <= '0;
      bus.rd_hit <= '0;
      bus.rd_val <= '0;
      bus.wr_done <= 1'b0;
      bus.wr_hit <= 1'b0;
      bus.evict_valid <= 1'b0;
      bus.evict_addr <= '0;
    end else begin
      bus.rd_done <= bus.rd_valid;
      for (int i = 0; i < NUM_RD; i++)
        if (bus.rd_valid[i]) begin
          bus.rd_hit[i] <= hit_c[i];
          bus.rd_val[i*LINE_WIDTH +: LINE_WIDTH] <= val_c[i*LINE_WIDTH +: LINE_WIDTH];
        end
      refb <= refb | rd_ref;
      bus.wr_done <= 1'b0;
      bus.evict_valid <= 1'b0;
      if (accept) begin
        if (bus.wr_inval || w_hit) begin
          bus.wr_done <= 1'b1;
          bus.wr_hit <= w_hit;
          if (w_hit) begin
            valid[w_idx] <= !bus.wr_inval;
            refb[w_idx] <= !bus.wr_inval;
            if (!bus.wr_inval) val_q[w_idx] <= bus.wr_val;
          end
        end else if (any_free) begin
          bus.wr_done <= 1'b1;
          bus.wr_hit <= 1'b0;
          valid[f_idx] <= 1'b1;
          refb[f_idx] <= 1'b1;
          addr_q[f_idx] <= bus.wr_addr;
          val_q[f_idx] <= bus.wr_val;
        end else begin
          lat_addr <= bus.wr_addr;
          lat_val <= bus.wr_val;
          state <= SCAN;
        end
      end else if (state == SCAN) begin
        ptr <= ptr + 1'b1;
        if (refb[ptr]) refb[ptr] <= rd_ref[ptr];
        else begin
          bus.evict_addr <= addr_q[ptr];
          bus.evict_valid <= 1'b1;
          bus.wr_done <= 1'b1;
          bus.wr_hit <= 1'b0;
          addr_q[ptr] <= lat_addr;
          val_q[ptr] <= lat_val;
          refb[ptr] <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_multiport_clock_cache.sv
// tb_multiport_clock_cache: directed scenarios plus random traffic checked against a behavioural model
module tb_multiport_clock_cache;
  localparam int AW = 8;
  localparam int LW = 32;
  localparam int K = 4;
  localparam int NR = 2;
  logic clock = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;
  multiport_clock_cache_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .NUM_RD(NR)) bus ();
  multiport_clock_cache #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .K(K), .NUM_RD(NR)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  logic [K-1:0] m_valid, m_ref;
  logic [AW-1:0] m_addr[K];
  logic [LW-1:0] m_val[K];
  int m_ptr;
  bit busy;
  logic [AW-1:0] l_addr;
  logic [LW-1:0] l_val;
  logic [NR-1:0] e_rd_done, e_rd_hit;
  logic [NR*LW-1:0] e_rd_val;
  logic e_wr_done, e_wr_hit, e_ev, e_wr_ready;
  logic [AW-1:0] e_ev_addr;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int find(input logic [AW-1:0] a);
    for (int k = 0; k < K; k++) if (m_valid[k] && m_addr[k] == a) return k;
    return -1;
  endfunction
  function automatic int first_free();
    for (int k = 0; k < K; k++) if (!m_valid[k]) return k;
    return -1;
  endfunction
  task automatic put(input int k, input logic [AW-1:0] a, input logic [LW-1:0] v);
    m_valid[k] = 1'b1;
    m_ref[k] = 1'b1;
    m_addr[k] = a;
    m_val[k] = v;
  endtask
  // advance the model across the coming clock edge using the inputs now applied
  task automatic step();
    logic [K-1:0] rref, killed;
    int h;
    if (reset) begin
      m_valid = '0; m_ref = '0; m_ptr = 0; busy = 0;
      e_rd_done = '0; e_rd_hit = '0; e_rd_val = '0;
      e_wr_done = 0; e_wr_hit = 0; e_ev = 0; e_ev_addr = '0; e_wr_ready = 0;
      return;
    end
    rref = '0;
    killed = '0;
    e_rd_done = bus.rd_valid;
    for (int i = 0; i < NR; i++)
      if (bus.rd_valid[i]) begin
        h = find(bus.rd_addr[i*AW +: AW]);
        e_rd_hit[i] = h >= 0;
        e_rd_val[i*LW +: LW] = h >= 0 ? m_val[h] : '0;
        if (h >= 0) rref[h] = 1'b1;
      end
    e_wr_done = 0;
    e_ev = 0;
    if (!busy && bus.wr_req) begin
      h = find(bus.wr_addr);
      if (bus.wr_inval) begin
        e_wr_done = 1; e_wr_hit = h >= 0;
        if (h >= 0) begin m_valid[h] = 0; m_ref[h] = 0; killed[h] = 1; end
      end else if (h >= 0) begin
        e_wr_done = 1; e_wr_hit = 1; m_val[h] = bus.wr_val; m_ref[h] = 1;
      end else if (first_free() >= 0) begin
        e_wr_done = 1; e_wr_hit = 0; put(first_free(), bus.wr_addr, bus.wr_val);
      end else begin
        busy = 1; l_addr = bus.wr_addr; l_val = bus.wr_val;
      end
    end else if (busy) begin
      if (m_ref[m_ptr]) m_ref[m_ptr] = 0;
      else begin
        e_ev = 1; e_ev_addr = m_addr[m_ptr]; e_wr_done = 1; e_wr_hit = 0;
        put(m_ptr, l_addr, l_val);
        busy = 0;
      end
      m_ptr = (m_ptr + 1) % K;
    end
    for (int k = 0; k < K; k++) if (rref[k] && !killed[k]) m_ref[k] = 1;
    e_wr_ready = !busy;
  endtask
  task automatic tick();
    step();
    @(posedge clock);
    #1;
    chk("rd_done", 64'(bus.rd_done), 64'(e_rd_done));
    chk("rd_hit", 64'(bus.rd_hit), 64'(e_rd_hit));
    chk("rd_val", 64'(bus.rd_val), 64'(e_rd_val));
    chk("wr_done", 64'(bus.wr_done), 64'(e_wr_done));
    chk("wr_hit", 64'(bus.wr_hit), 64'(e_wr_hit));
    chk("evict_valid", 64'(bus.evict_valid), 64'(e_ev));
    chk("evict_addr", 64'(bus.evict_addr), 64'(e_ev_addr));
    chk("wr_ready", 64'(bus.wr_ready), 64'(e_wr_ready));
  endtask
  task automatic idle_in();
    bus.rd_valid = '0; bus.rd_addr = '0;
    bus.wr_req = 0; bus.wr_inval = 0; bus.wr_addr = '0; bus.wr_val = '0;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [LW-1:0] v, input logic inv);
    bus.wr_req = 1; bus.wr_inval = inv; bus.wr_addr = a; bus.wr_val = v;
    tick();
    bus.wr_req = 0; bus.wr_inval = 0;
  endtask
  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [NR-1:0] v);
    bus.rd_valid = v; bus.rd_addr = {a1, a0};
  endtask
  task automatic wait_done(output int n);
    n = 1;
    while (!bus.wr_done && n < 20) begin
      tick();
      n++;
    end
    chk("wait_done", 64'(bus.wr_done), 64'd1);
  endtask
  initial begin
    int n;
    idle_in();
    reset = 1;
    tick();
    tick();
    chk("reset_ready", 64'(bus.wr_ready), 64'd0);
    chk("reset_rd_done", 64'(bus.rd_done), 64'd0);
    reset = 0;
    #1;
    chk("ready_after_reset", 64'(bus.wr_ready), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      wr(8'(i * 16), 32'hD000_0000 | i * 16, 0);
      chk("fill_done", 64'(bus.wr_done), 64'd1);
      chk("fill_ev", 64'(bus.evict_valid), 64'd0);
    end
    rd(8'h20, 8'h99, 2'b11);
    tick();
    rd(0, 0, 2'b00);
    chk("rd2_done", 64'(bus.rd_done), 64'h3);
    chk("rd2_hit", 64'(bus.rd_hit), 64'h1);
    chk("rd2_val0", 64'(bus.rd_val[31:0]), 64'hD000_0020);
    chk("rd2_val1", 64'(bus.rd_val[63:32]), 64'h0);
    wr(8'h50, 32'h5555_0050, 0);
    chk("scan_ready", 64'(bus.wr_ready), 64'd0);
    wait_done(n);
    chk("evict_latency", 64'(n), 64'(K + 2));
    chk("evict_10", 64'(bus.evict_addr), 64'h10);
    rd(8'h50, 8'h10, 2'b11);
    tick();
    chk("after_ev_hit", 64'(bus.rd_hit), 64'h1);
    chk("after_ev_val", 64'(bus.rd_val[31:0]), 64'h5555_0050);
    rd(8'h30, 8'h00, 2'b01);
    wr(8'h60, 32'h6, 0);
    rd(0, 0, 2'b00);
    wait_done(n);
    chk("evict_20", 64'(bus.evict_addr), 64'h20);
    chk("evict_20_lat", 64'(n), 64'd2);
    wr(8'h70, 32'h7, 0);
    wait_done(n);
    chk("evict_40", 64'(bus.evict_addr), 64'h40);
    wr(8'h30, 32'hBEEF_0030, 0);
    chk("whit_30", 64'(bus.wr_hit), 64'd1);
    wr(8'h30, 32'h0, 1);
    chk("inval_30", 64'(bus.wr_hit), 64'd1);
    rd(8'h30, 8'h30, 2'b11);
    tick();
    rd(0, 0, 2'b00);
    chk("inval_miss", 64'(bus.rd_hit), 64'h0);
    wr(8'h80, 32'h8, 0);
    chk("refill_done", 64'(bus.wr_done), 64'd1);
    chk("refill_noev", 64'(bus.evict_valid), 64'd0);
    wr(8'h90, 32'h9, 0);
    tick();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;
    chk("ready_after_abort", 64'(bus.wr_ready), 64'd1);
    rd(8'h50, 8'h90, 2'b11);
    tick();
    chk("abort_miss", 64'(bus.rd_hit), 64'h0);
    for (int c = 0; c < 3000; c++) begin
      bus.rd_valid = NR'($urandom);
      for (int i = 0; i < NR; i++) bus.rd_addr[i*AW +: AW] = {4'($urandom_range(1, 7)), 4'h0};
      bus.wr_req = $urandom_range(0, 2) == 0;
      bus.wr_inval = $urandom_range(0, 3) == 0;
      bus.wr_addr = {4'($urandom_range(1, 6)), 4'h0};
      bus.wr_val = $urandom;
      reset = $urandom_range(0, 299) == 0;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
